// File: rtl/img_proc_pkg.sv
// Shared definitions for the grayscale image pipeline.
//   SYNC0/SYNC1 : frame sync bytes that open every transmitted frame
//   HDR_LEN     : header length in bytes (2 sync + 16-bit width + 16-bit height)
//   frame_state_e : frame sequencer states. SEND/ACKHI/ACKLO are the
//                   phases of the UART byte handshake.
//   phase_e     : which part of the frame the byte in flight belongs to
//   hdr_byte()  : header byte for a given index
package img_proc_pkg;

  localparam logic [7:0] SYNC0   = 8'hA5;
  localparam logic [7:0] SYNC1   = 8'h5A;
  localparam int         HDR_LEN = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_WAITPIX,
    ST_SEND,
    ST_ACKHI,
    ST_ACKLO,
    ST_CHK,
    ST_DONE
  } frame_state_e;

  typedef enum logic [1:0] {
    PH_HDR,
    PH_PIX,
    PH_CHK
  } phase_e;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx,
                                          input logic [15:0] w,
                                          input logic [15:0] h);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = SYNC0;
      3'd1:    b = SYNC1;
      3'd2:    b = w[15:8];
      3'd3:    b = w[7:0];
      3'd4:    b = h[15:8];
      3'd5:    b = h[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_handshake.sv
// Byte-level handshake with the UART transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : a byte is waiting in data (held until byte_done)
//   data       : byte to send; passed straight to tx_data
//   tx_busy    : UART busy
//   tx_start   : one-cycle send strobe
//   tx_data    : byte presented to the UART
//   byte_done  : one-cycle pulse once the UART has finished the byte
//   state      : handshake phase (ST_SEND / ST_ACKHI / ST_ACKLO)
//
// Handshake: tx_start is raised only in ST_SEND while req=1 and tx_busy=0.
// The byte is then owned by the UART until tx_busy has been seen rising
// (ST_ACKHI) and falling again (ST_ACKLO); only that falling edge releases
// the byte, so a second tx_start can never precede a busy 1->0 transition.
module uart_tx_handshake
  import img_proc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [7:0]   data,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic         byte_done,
  output frame_state_e state
);

  frame_state_e state_next;

  assign tx_data = data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SEND;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    byte_done  = 1'b0;
    case (state)
      ST_ACKHI: if (tx_busy) state_next = ST_ACKLO;
      ST_ACKLO: begin
        if (!tx_busy) begin
          byte_done  = 1'b1;
          state_next = ST_SEND;
        end
      end
      default: begin
        if (req && !tx_busy) begin
          tx_start   = 1'b1;
          state_next = ST_ACKHI;
        end
      end
    endcase
  end

endmodule

// File: rtl/gray_frame_tx_seq.sv
// Frame sequencer: streams header, every gray pixel of the image ROM and an
// 8-bit additive checksum of the pixels to the UART.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : frame start request (IDLE only)
//   abort               : end the frame after the byte in flight
//   pix_addr, pix_req   : ROM address and one-cycle fetch strobe
//   pix_valid, pix_data : gray byte returned PIX_LAT cycles after pix_req
//   tx_start, tx_data   : UART send strobe and byte
//   tx_busy             : UART busy
//   busy                : frame in progress (any state but IDLE)
//   done, aborted       : end-of-frame pulse and its abort qualifier
//   state               : current state; the handshake phase while sending
module gray_frame_tx_seq
  import img_proc_pkg::*;
#(
  parameter int IMG_W   = 512,
  parameter int IMG_H   = 512,
  parameter int ADDR_W  = 18,
  parameter int PIX_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_req,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output frame_state_e      state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(longint'(IMG_W) * longint'(IMG_H) - 1);

  frame_state_e      frame_state, state_next;
  phase_e            phase, phase_next;
  logic [2:0]        hdr_idx, hdr_next;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        chk, chk_next;
  logic [7:0]        tx_byte, byte_next;
  logic              abort_q, abort_next;
  logic [7:0]        wait_cnt, wait_next;
  logic              lat_ok;
  logic              req, byte_done;
  frame_state_e      hs_state;

  assign busy    = (frame_state != ST_IDLE);
  assign aborted = done && abort_q;
  assign state   = (frame_state == ST_SEND) ? hs_state : frame_state;

  // A pixel can only be genuine once the ROM latency has elapsed; anything
  // earlier in WAITPIX is noise on pix_valid.
  assign lat_ok = int'(wait_cnt) >= PIX_LAT - 1;

  uart_tx_handshake u_hs (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (tx_byte),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .byte_done (byte_done),
    .state     (hs_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_state <= ST_IDLE;
      phase       <= PH_HDR;
      hdr_idx     <= '0;
      pix_addr    <= '0;
      chk         <= '0;
      tx_byte     <= '0;
      abort_q     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      frame_state <= state_next;
      phase       <= phase_next;
      hdr_idx     <= hdr_next;
      pix_addr    <= addr_next;
      chk         <= chk_next;
      tx_byte     <= byte_next;
      abort_q     <= abort_next;
      wait_cnt    <= wait_next;
    end
  end

  always_comb begin
    state_next = frame_state;
    phase_next = phase;
    hdr_next   = hdr_idx;
    addr_next  = pix_addr;
    chk_next   = chk;
    byte_next  = tx_byte;
    abort_next = abort_q | (abort && busy);
    wait_next  = wait_cnt;
    pix_req    = 1'b0;
    req        = 1'b0;
    done       = 1'b0;
    case (frame_state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_HDR;
          phase_next = PH_HDR;
          hdr_next   = '0;
          addr_next  = '0;
          chk_next   = '0;
          abort_next = 1'b0;
        end
      end
      ST_HDR: begin
        byte_next  = hdr_byte(hdr_idx, 16'(IMG_W), 16'(IMG_H));
        state_next = ST_SEND;
      end
      ST_FETCH: begin
        pix_req    = 1'b1;
        wait_next  = '0;
        state_next = ST_WAITPIX;
      end
      ST_WAITPIX: begin
        if (wait_cnt != 8'hFF) wait_next = wait_cnt + 8'd1;
        if (pix_valid && lat_ok) begin
          byte_next  = pix_data;
          chk_next   = chk + pix_data;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        req = 1'b1;
        if (byte_done) begin
          if (abort_q) begin
            state_next = ST_DONE;
          end else begin
            case (phase)
              PH_HDR: begin
                if (hdr_idx == 3'(HDR_LEN - 1)) begin
                  phase_next = PH_PIX;
                  state_next = ST_FETCH;
                end else begin
                  hdr_next   = hdr_idx + 3'd1;
                  state_next = ST_HDR;
                end
              end
              PH_PIX: begin
                if (pix_addr == LAST_ADDR) begin
                  state_next = ST_CHK;
                end else begin
                  addr_next  = pix_addr + ADDR_W'(1);
                  state_next = ST_FETCH;
                end
              end
              default: state_next = ST_DONE;
            endcase
          end
        end
      end
      ST_CHK: begin
        byte_next  = chk;
        phase_next = PH_CHK;
        state_next = ST_SEND;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gray_frame_tx_seq.sv
// Bench for gray_frame_tx_seq on a 4x2 image: behavioural ROM with fixed
// latency, behavioural UART with programmable busy time, and an expected
// byte queue built from the frame format.
module tb_gray_frame_tx_seq;
  import img_proc_pkg::*;

  localparam int IMG_W   = 4;
  localparam int IMG_H   = 2;
  localparam int ADDR_W  = 4;
  localparam int PIX_LAT = 2;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam int BUDGET  = 4000;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, abort;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_req, pix_valid;
  logic [7:0]        pix_data;
  logic              tx_start, tx_busy;
  logic [7:0]        tx_data;
  logic              busy, done, aborted;
  frame_state_e      dut_state;

  gray_frame_tx_seq #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_LAT(PIX_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pix_addr(pix_addr), .pix_req(pix_req), .pix_valid(pix_valid),
    .pix_data(pix_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .busy(busy), .done(done), .aborted(aborted),
    .state(dut_state)
  );

  // ---------------- environment models ----------------
  logic [7:0]        rom [0:NPIX-1];
  int                uart_len;
  logic              hold, glitch;
  logic [7:0]        glitch_data;
  logic              v1, v2;
  logic [ADDR_W-1:0] a1;
  logic [7:0]        d2, ubyte;
  int                ucnt;
  logic              ubusy;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int done_cnt, abort_seen, viol_cnt, txs_cnt;
  int n_checks, n_fail;

  assign tx_busy   = ubusy | hold;
  assign pix_valid = v2 | glitch;
  assign pix_data  = glitch ? glitch_data : d2;

  // ROM + gray register: data appears PIX_LAT=2 cycles after the request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; a1 <= '0; d2 <= '0;
    end else begin
      v1 <= pix_req;
      a1 <= pix_addr;
      v2 <= v1;
      d2 <= rom[a1[2:0]];
    end
  end

  // UART: busy for uart_len cycles per byte; records bytes and protocol slips.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt  <= 0;
      ubusy <= 1'b0;
    end else begin
      if (tx_start) begin
        txs_cnt <= txs_cnt + 1;
        if (tx_busy) viol_cnt <= viol_cnt + 1;
        got_q.push_back(tx_data);
        ubyte <= tx_data;
        ucnt  <= uart_len;
        ubusy <= 1'b1;
      end else if (ucnt > 1) begin
        ucnt <= ucnt - 1;
      end else begin
        ucnt  <= 0;
        ubusy <= 1'b0;
      end
      if (ubusy && !tx_start && tx_data !== ubyte) viol_cnt <= viol_cnt + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (aborted) abort_seen <= abort_seen + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic build_exp();
    int sum;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'((IMG_W >> 8) & 255));
    exp_q.push_back(8'(IMG_W & 255));
    exp_q.push_back(8'((IMG_H >> 8) & 255));
    exp_q.push_back(8'(IMG_H & 255));
    sum = 0;
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back(rom[i]);
      sum = sum + int'(rom[i]);
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic clear_obs();
    got_q.delete();
    done_cnt = 0; abort_seen = 0; viol_cnt = 0; txs_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input bit spam, output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      start       = spam && busy && ($urandom_range(0, 3) == 0);
      glitch      = spam && tx_busy && ($urandom_range(0, 2) == 0);
      glitch_data = 8'($urandom);
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    start  = 1'b0;
    glitch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bytes(input int n, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (got_q.size() >= n) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; glitch = 1'b0;
    glitch_data = 8'h00; uart_len = 4;
    for (int i = 0; i < NPIX; i++) rom[i] = 8'h00;
    clear_obs();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pix_addr, pix_req, tx_start, tx_data, busy, done, aborted} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs addr=%0h req=%0b txs=%0b txd=%0h busy=%0b done=%0b ab=%0b want all 0",
               pix_addr, pix_req, tx_start, tx_data, busy, done, aborted);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut_state !== ST_IDLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle state=%0d busy=%0b want state=%0d busy=0", dut_state, busy, ST_IDLE);
    end
  endtask

  task automatic test_basic_frame();
    bit to;
    for (int i = 0; i < NPIX; i++) rom[i] = 8'h10 + 8'(i);
    uart_len = 10;
    build_exp();
    clear_obs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_latency busy=%0b tx_start=%0b want 1/0", busy, tx_start);
    end
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_first_tx tx_start=%0b tx_data=%0h want 1/a5", tx_start, tx_data);
    end
    wait_done(1'b0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_timeout done=0 want 1"); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_len got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_byte[%0d] got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (got_q.size() == 15 && got_q[14] !== 8'h9C) begin
      n_fail++;
      $display("FAIL basic_chk got %0h want 9c", got_q[14]);
    end
    n_checks++;
    if (done_cnt != 1 || abort_seen != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end done_cnt=%0d aborted=%0d busy=%0b want 1/0/0", done_cnt, abort_seen, busy);
    end
    n_checks++;
    if (viol_cnt != 0 || txs_cnt != 15) begin
      n_fail++;
      $display("FAIL basic_protocol viol=%0d starts=%0d want 0/15", viol_cnt, txs_cnt);
    end
  endtask

  task automatic test_busy_hold();
    bit to;
    for (int i = 0; i < NPIX; i++) rom[i] = 8'($urandom);
    uart_len = $urandom_range(2, 8);
    build_exp();
    clear_obs();
    hold = 1'b1;
    pulse_start();
    repeat (50) @(negedge clk);
    n_checks++;
    if (txs_cnt != 0) begin
      n_fail++;
      $display("FAIL hold_no_start starts=%0d want 0", txs_cnt);
    end
    hold = 1'b0;
    wait_done(1'b0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL hold_timeout done=0 want 1"); end
    n_checks++;
    if (got_q.size() != exp_q.size() || txs_cnt != exp_q.size()) begin
      n_fail++;
      $display("FAIL hold_len got %0d starts %0d want %0d", got_q.size(), txs_cnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL hold_byte[%0d] got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (viol_cnt != 0) begin n_fail++; $display("FAIL hold_protocol viol=%0d want 0", viol_cnt); end
  endtask

  task automatic test_abort();
    bit to;
    for (int i = 0; i < NPIX; i++) rom[i] = 8'($urandom);
    uart_len = $urandom_range(3, 8);
    build_exp();
    while (exp_q.size() > HDR_LEN + 4) void'(exp_q.pop_back());
    clear_obs();
    pulse_start();
    wait_bytes(HDR_LEN + 4, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL abort_reach_pixel3 bytes=%0d want %0d", got_q.size(), HDR_LEN + 4); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(1'b0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL abort_timeout done=0 want 1"); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL abort_len got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort_byte[%0d] got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_cnt != 1 || abort_seen != 1 || busy !== 1'b0 || dut_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_end done_cnt=%0d aborted=%0d busy=%0b state=%0d want 1/1/0/%0d",
               done_cnt, abort_seen, busy, dut_state, ST_IDLE);
    end
  endtask

  task automatic test_start_glitch();
    bit to;
    for (int i = 0; i < NPIX; i++) rom[i] = 8'h10 + 8'(i);
    uart_len = 10;
    build_exp();
    clear_obs();
    pulse_start();
    wait_done(1'b1, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL glitch_timeout done=0 want 1"); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL glitch_len got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL glitch_byte[%0d] got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_cnt != 1 || abort_seen != 0 || viol_cnt != 0) begin
      n_fail++;
      $display("FAIL glitch_end done_cnt=%0d aborted=%0d viol=%0d want 1/0/0", done_cnt, abort_seen, viol_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    for (int i = 0; i < NPIX; i++) rom[i] = 8'($urandom);
    uart_len = $urandom_range(2, 8);
    build_exp();
    clear_obs();
    pulse_start();
    wait_bytes(HDR_LEN + 6, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rstmid_reach_pixel5 bytes=%0d want %0d", got_q.size(), HDR_LEN + 6); end
    repeat ($urandom_range(0, 4)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pix_addr, pix_req, tx_start, tx_data, busy, done, aborted} !== '0 || dut_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rstmid_outputs addr=%0h req=%0b txs=%0b txd=%0h busy=%0b done=%0b ab=%0b state=%0d want all 0/IDLE",
               pix_addr, pix_req, tx_start, tx_data, busy, done, aborted, dut_state);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_done done_cnt=%0d want 0", done_cnt); end
    clear_obs();
    pulse_start();
    wait_done(1'b0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rstmid_timeout done=0 want 1"); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rstmid_len got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_byte[%0d] got %0h want %0h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_chk_wrap();
    bit to;
    for (int i = 0; i < NPIX; i++) rom[i] = 8'hFF;
    uart_len = 2;
    build_exp();
    clear_obs();
    pulse_start();
    wait_done(1'b0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL wrap_timeout done=0 want 1"); end
    n_checks++;
    if (got_q.size() != 15 || got_q[got_q.size() - 1] !== 8'hF8) begin
      n_fail++;
      $display("FAIL wrap_chk len=%0d last=%0h want 15/f8", got_q.size(),
               (got_q.size() > 0) ? got_q[got_q.size() - 1] : 8'h00);
    end
  endtask

  task automatic test_random_frames();
    bit to;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NPIX; i++) rom[i] = 8'($urandom);
      uart_len = $urandom_range(1, 12);
      build_exp();
      clear_obs();
      pulse_start();
      wait_done(1'b0, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL rand%0d_timeout done=0 want 1", r); end
      n_checks++;
      if (got_q.size() != exp_q.size() || viol_cnt != 0) begin
        n_fail++;
        $display("FAIL rand%0d_len got %0d viol %0d want %0d/0", r, got_q.size(), viol_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_byte[%0d] got %0h want %0h", r, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_frame();
    test_busy_hold();
    test_abort();
    test_start_glitch();
    test_reset_mid();
    test_chk_wrap();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
